// File: rtl/lm32_ram_ctl.sv
// Pseudo-dual-port RAM with byte-lane writes, registered read port and post-reset clear sequencer.
// Optional macro LM32_RAM_BYPASS_EN: same-cycle same-address read returns the merged (new) word.
module lm32_ram_ctl #(
  parameter int unsigned           data_width     = 32,
  parameter int unsigned           address_width  = 10,
  parameter int unsigned           byte_width     = 8,
  parameter logic [data_width-1:0] init_value     = '0,
  parameter bit                    clear_on_reset = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 enable_read,
  input  logic [address_width-1:0]             read_address,
  input  logic                                 enable_write,
  input  logic [address_width-1:0]             write_address,
  input  logic [data_width-1:0]                write_data,
  input  logic [data_width/byte_width-1:0]     write_byte_enable,
  output logic [data_width-1:0]                read_data,
  output logic                                 read_valid,
  output logic                                 init_busy
);
  localparam int unsigned DEPTH     = 1 << address_width;
  localparam int unsigned NUM_LANES = data_width / byte_width;
  localparam logic [address_width-1:0] LAST_ADDR = address_width'(DEPTH - 1);
  localparam logic [address_width-1:0] CNT_ONE   = address_width'(1);

  if (data_width % byte_width != 0) begin : g_bad_width
    $error("lm32_ram_ctl: data_width must be a multiple of byte_width");
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                   state_q, state_d;
  logic [address_width-1:0] clr_cnt_q, clr_cnt_d;
  logic                     clr_we;
  logic                     run;
  logic [data_width-1:0]    read_data_q;
  logic                     read_valid_q;

  logic [address_width-1:0] wr_addr;
  logic [data_width-1:0]    wr_word;
  logic [NUM_LANES-1:0]     lane_we;
  logic [data_width-1:0]    rd_word;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= clear_on_reset ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Termination is by address compare, so the counter wrapping back to 0 is harmless.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_CLEAR);

  assign wr_addr = clr_we ? clr_cnt_q : write_address;
  assign wr_word = clr_we ? init_value : write_data;

`ifdef LM32_RAM_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = run & enable_write & enable_read & (write_address == read_address);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [byte_width-1:0] mem_q [DEPTH];

    assign lane_we[i] = clr_we | (run & enable_write & write_byte_enable[i]);

    always_ff @(posedge clk_i) begin
      if (lane_we[i]) mem_q[wr_addr] <= wr_word[i*byte_width +: byte_width];
    end

`ifdef LM32_RAM_BYPASS_EN
    assign rd_word[i*byte_width +: byte_width] = (bypass_hit && write_byte_enable[i])
                                                 ? write_data[i*byte_width +: byte_width]
                                                 : mem_q[read_address];
`else
    assign rd_word[i*byte_width +: byte_width] = mem_q[read_address];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= run & enable_read;
      if (run && enable_read) read_data_q <= rd_word;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_lm32_ram_ctl.sv
// Self-checking bench for lm32_ram_ctl: directed scenarios plus random traffic against an array model.
module tb_lm32_ram_ctl;
  localparam int AW = 4, DW = 32, NL = 4, DEPTH = 16;
  localparam logic [DW-1:0] INIT_A = 32'h0000_0000;
  localparam logic [DW-1:0] INIT_B = 32'h5A5A_5A5A;

  logic          clk_i = 1'b0, rst_n_i = 1'b0;
  logic          en_r = 1'b0, en_w = 1'b0;
  logic [AW-1:0] ra = '0, wa = '0;
  logic [DW-1:0] wd = '0;
  logic [NL-1:0] be = '0;
  logic [DW-1:0] rd_a, rd_b;
  logic          vld_a, vld_b, busy_a, busy_b;

  int n_cmp = 0, n_err = 0;

  always #5 clk_i = ~clk_i;

  lm32_ram_ctl #(.data_width(DW), .address_width(AW), .byte_width(8),
                 .init_value(INIT_A), .clear_on_reset(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_read(en_r), .read_address(ra),
    .enable_write(en_w), .write_address(wa), .write_data(wd), .write_byte_enable(be),
    .read_data(rd_a), .read_valid(vld_a), .init_busy(busy_a));

  lm32_ram_ctl #(.data_width(DW), .address_width(AW), .byte_width(8),
                 .init_value(INIT_B), .clear_on_reset(1'b1)) u_dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_read(en_r), .read_address(ra),
    .enable_write(en_w), .write_address(wa), .write_data(wd), .write_byte_enable(be),
    .read_data(rd_b), .read_valid(vld_b), .init_busy(busy_b));

  // Reference model: word arrays, expected read register and remaining clear cycles.
  logic [DW-1:0] m_a [DEPTH];
  logic [DW-1:0] m_b [DEPTH];
  logic [DW-1:0] e_rd_a = '0, e_rd_b = '0;
  logic          e_vld = 1'b0;
  int            clear_left = DEPTH;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [NL-1:0] en);
    for (int i = 0; i < NL; i++) if (en[i]) old[i*8 +: 8] = nw[i*8 +: 8];
    return old;
  endfunction

  task automatic tick();
    if (clear_left > 0) begin
      m_a[DEPTH - clear_left] = INIT_A;
      m_b[DEPTH - clear_left] = INIT_B;
      clear_left--;
      e_vld = 1'b0;
    end else begin
      e_vld = en_r;
      if (en_r) begin
        e_rd_a = m_a[ra];
        e_rd_b = m_b[ra];
`ifdef LM32_RAM_BYPASS_EN
        if (en_w && wa == ra) begin
          e_rd_a = merge(e_rd_a, wd, be);
          e_rd_b = merge(e_rd_b, wd, be);
        end
`endif
      end
      if (en_w) begin
        m_a[wa] = merge(m_a[wa], wd, be);
        m_b[wa] = merge(m_b[wa], wd, be);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    en_r = 1'b0; en_w = 1'b0; be = '0;
  endtask

  task automatic assert_rst();
    idle();
    rst_n_i = 1'b0;
    e_rd_a = '0; e_rd_b = '0; e_vld = 1'b0; clear_left = DEPTH;
    @(posedge clk_i); #1;
  endtask

  task automatic release_rst();
    rst_n_i = 1'b1;
    clear_left = DEPTH;
  endtask

  task automatic test_reset();
    assert_rst();
    n_cmp++; if (rd_a !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h want 00000000", rd_a); end
    n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", vld_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    release_rst();
    for (int k = 0; k <= DEPTH; k++) begin
      n_cmp++;
      if (busy_a !== (k < DEPTH)) begin
        n_err++; $display("FAIL busy_window k=%0d: got %b want %b", k, busy_a, (k < DEPTH));
      end
      if (k < DEPTH) tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      en_r = 1'b1; ra = AW'(a);
      tick();
      n_cmp++;
      if (vld_a !== 1'b1 || rd_a !== INIT_A) begin
        n_err++; $display("FAIL clear_read a=%0d: got %h/%b want %h/1", a, rd_a, vld_a, INIT_A);
      end
    end
    idle(); tick();
    n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL vld_drop: got %b want 0", vld_a); end
  endtask

  task automatic test_byte_enable();
    en_w = 1'b1; wa = 4'd5; wd = 32'h1122_3344; be = 4'hF; tick();
    wd = 32'hAABB_CCDD; be = 4'h2; tick();
    idle(); en_r = 1'b1; ra = 4'd5; tick();
    n_cmp++;
    if (rd_a !== 32'h1122_CC44 || vld_a !== 1'b1) begin
      n_err++; $display("FAIL byte_enable: got %h/%b want 1122cc44/1", rd_a, vld_a);
    end
    idle(); tick();
    n_cmp++; if (rd_a !== 32'h1122_CC44) begin n_err++; $display("FAIL rd_hold: got %h want 1122cc44", rd_a); end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] exp;
    en_w = 1'b1; wa = 4'd9; wd = 32'h0; be = 4'hF; tick();
    wd = 32'hCAFE_F00D; en_r = 1'b1; ra = 4'd9; tick();
`ifdef LM32_RAM_BYPASS_EN
    exp = 32'hCAFE_F00D;
`else
    exp = 32'h0000_0000;
`endif
    n_cmp++;
    if (rd_a !== exp) begin n_err++; $display("FAIL same_addr: got %h want %h", rd_a, exp); end
    en_w = 1'b0; tick();
    n_cmp++;
    if (rd_a !== 32'hCAFE_F00D) begin n_err++; $display("FAIL same_addr_next: got %h want cafef00d", rd_a); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_clear();
    assert_rst(); release_rst();
    for (int k = 0; k < 7; k++) tick();
    rst_n_i = 1'b0;
    e_rd_a = '0; e_rd_b = '0; e_vld = 1'b0;
    #2;
    n_cmp++;
    if (busy_b !== 1'b1 || vld_b !== 1'b0 || rd_b !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got busy=%b vld=%b rd=%h want 1/0/0", busy_b, vld_b, rd_b);
    end
    @(posedge clk_i); #1;
    release_rst();
    for (int k = 0; k <= DEPTH; k++) begin
      n_cmp++;
      if (busy_b !== (k < DEPTH)) begin
        n_err++; $display("FAIL restart_busy k=%0d: got %b want %b", k, busy_b, (k < DEPTH));
      end
      if (k < DEPTH) tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      en_r = 1'b1; ra = AW'(a);
      tick();
      n_cmp++;
      if (rd_b !== INIT_B || vld_b !== 1'b1 || rd_a !== INIT_A) begin
        n_err++; $display("FAIL restart_read a=%0d: got %h/%b/%h want %h/1/%h", a, rd_b, vld_b, rd_a, INIT_B, INIT_A);
      end
    end
    idle(); tick();
  endtask

  task automatic test_clear_ignore();
    assert_rst(); release_rst();
    tick(); tick();
    en_w = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF; be = 4'hF; en_r = 1'b1; ra = 4'd3;
    tick();
    n_cmp++;
    if (vld_a !== 1'b0 || rd_a !== 32'h0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL clear_ignore: got vld=%b rd=%h busy=%b want 0/0/1", vld_a, rd_a, busy_a);
    end
    idle();
    for (int k = 0; k < 2 * DEPTH && clear_left > 0; k++) tick();
    en_r = 1'b1; ra = 4'd3; tick();
    n_cmp++;
    if (rd_a !== 32'h0 || vld_a !== 1'b1) begin
      n_err++; $display("FAIL clear_ignore_after: got %h/%b want 00000000/1", rd_a, vld_a);
    end
    idle(); tick();
  endtask

  task automatic test_back_to_back();
    en_w = 1'b1; be = 4'hF;
    for (int a = 1; a <= 4; a++) begin wa = AW'(a); wd = DW'(a); tick(); end
    idle();
    for (int a = 1; a <= 4; a++) begin
      en_r = 1'b1; ra = AW'(a);
      tick();
      n_cmp++;
      if (vld_a !== 1'b1 || rd_a !== DW'(a)) begin
        n_err++; $display("FAIL back_to_back a=%0d: got %h/%b want %h/1", a, rd_a, vld_a, DW'(a));
      end
    end
    idle(); tick();
    n_cmp++;
    if (vld_a !== 1'b0 || rd_a !== 32'h4) begin
      n_err++; $display("FAIL back_to_back_end: got %h/%b want 00000004/0", rd_a, vld_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en_r = 1'($urandom_range(0, 1));
      en_w = 1'($urandom_range(0, 1));
      wa   = AW'($urandom_range(0, DEPTH - 1));
      ra   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      wd   = DW'($urandom);
      be   = NL'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (vld_a !== e_vld || rd_a !== e_rd_a || vld_b !== e_vld || rd_b !== e_rd_b) begin
        n_err++;
        $display("FAIL random c=%0d: got a=%h/%b b=%h/%b want a=%h b=%h vld=%b",
                 c, rd_a, vld_a, rd_b, vld_b, e_rd_a, e_rd_b, e_vld);
      end
    end
    idle(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_same_addr();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_clear_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lm32_ram_ctl.md
Name: lm32_ram_ctl

Overview:
- Single-clock pseudo-dual-port RAM with one read port and one write port, parametrised in data width, depth and byte-lane width.
- Adds per-byte write enables, a registered read port with a valid strobe, and a post-reset clear sequencer that fills the array with a fixed value.
- Used for the LM32 cache tag/data stores and the register file, where memory contents must be deterministic after reset.

Parameters:
data_width, 32, width of the read and write data ports in bits
address_width, 10, address bits; depth = 1 << address_width
byte_width, 8, bits per write lane; data_width must be an exact multiple of it
init_value, 0, value written to every word by the clear sequencer (data_width bits)
clear_on_reset, 1, 1 = run the clear sequencer after reset; 0 = skip it and leave contents undefined

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_n_i  input  1  asynchronous active-low reset
enable_read  input  1  read request; sampled on clk_i
read_address  input  address_width  read address
enable_write  input  1  write request; sampled on clk_i
write_address  input  address_width  write address
write_data  input  data_width  write data
write_byte_enable  input  data_width/byte_width  per-lane write enable; bit i covers write_data[i*byte_width +: byte_width]
read_data  output  data_width  registered read data
read_valid  output  1  one-cycle pulse, high the cycle after an accepted read
init_busy  output  1  clear sequencer active; all requests are ignored while high

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: read_data = 0; read_valid = 0; clear counter = 0.
  - init_busy = 1 if clear_on_reset = 1, else 0.
  - State = CLEAR if clear_on_reset = 1, else RUN.
- Elaboration: if data_width is not a multiple of byte_width, fail elaboration with an error.
- State machine:
  - CLEAR: each cycle writes init_value to the address held in the counter, then increments the counter.
  - CLEAR ends after address depth-1 is written; the FSM moves to RUN on the next edge.
  - init_busy is high for exactly depth cycles after reset release.
  - RUN: normal operation. RUN is left only by reset.
- During CLEAR:
  - enable_read and enable_write are ignored. No array update from the write port; read_valid stays 0; read_data holds its value.
- Reset mid-CLEAR: the counter returns to 0 and the clear restarts from address 0 when reset is released.
- Write (RUN, enable_write = 1): on the clock edge, lanes whose write_byte_enable bit is 1 take the matching write_data bytes; other lanes keep their contents.
  - write_byte_enable = 0 with enable_write = 1 is a legal no-op.
- Read (RUN, enable_read = 1):
  - read_data is updated on the edge from mem[read_address], so latency is 1 cycle.
  - read_valid = 1 in the following cycle.
  - When enable_read = 0, read_data holds its last value and read_valid = 0.
- Back-to-back reads give one result per cycle, in request order.
- Read and write in the same cycle to different addresses: fully independent.
- Read and write in the same cycle to the same address: result depends on the optional feature below.
- Address wrap: the clear counter is address_width bits wide. Termination is detected at depth-1, not by counter overflow.

Optional Feature:
- Macro: LM32_RAM_BYPASS_EN.
- Defined: a same-cycle read and write to the same address returns the merged word.
  - Lanes enabled for writing come from write_data; other lanes come from the old memory contents.
  - The merge is done by a forwarding mux in front of the read_data register, so read latency stays 1 cycle.
- Undefined: the same case returns the old (pre-write) contents on read_data. The new data is visible to reads issued in the next cycle or later.
- Clear-sequencer behaviour is identical either way.

Test Plan:
- All scenarios use address_width = 4 (depth 16), clear_on_reset = 1, init_value = 0 unless stated otherwise.
- Release rst_n_i -> init_busy high for exactly 16 cycles, then low. Reads of addresses 0..15 each return 0x00000000, with read_valid high one cycle after each read request.
- Write 0x11223344 to address 5 with byte enable 0xF. Then write 0xAABBCCDD to address 5 with byte enable 0x2. Read address 5 -> read_data = 0x1122CC44.
- Pre-load address 9 with 0x0. In one cycle, write 0xCAFEF00D to address 9 (byte enable 0xF) and read address 9.
  - Built with LM32_RAM_BYPASS_EN -> read_data = 0xCAFEF00D.
  - Built without it -> read_data = 0x00000000; a read in the next cycle returns 0xCAFEF00D.
- Assert rst_n_i low during clear cycle 7, then release -> init_busy high for a full 16 more cycles. All locations read init_value; use init_value = 0x5A5A5A5A for this run.
- Drive write 0xDEADBEEF to address 3 and a read request during clear cycle 2 -> read_valid stays 0. After clear, address 3 reads 0x00000000.
- Four consecutive read requests to addresses 1, 2, 3, 4, pre-loaded with 0x1, 0x2, 0x3, 0x4 -> read_valid high for 4 consecutive cycles; read_data = 0x1, 0x2, 0x3, 0x4 in that order.
